// File: rtl/rtc_read_ctrl.sv
// rtc_read_ctrl
//   Sequences one read cycle on a multiplexed address/data RTC bus:
//   address phase (ALE high), address hold, read strobe with data capture,
//   recovery, then a one-cycle done pulse.
//
// Parameters (0 is treated as 1, legal range 1..255):
//   T_ALE  - cycles ALE is high with the address driven
//   T_HOLD - cycles the address stays on the bus after ALE falls
//   T_RD   - cycles CS_N/RD_N are low
//   T_REC  - recovery cycles after RD_N rises
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   arranque   - read request level, held high until listo
//   addr       - RTC register address to read
//   ad_in      - multiplexed bus input from the pad
//   ad_out     - address driven onto the bus
//   ad_oe      - bus output enable (1 = drive ad_out)
//   ale        - address latch enable, active-high
//   cs_n       - chip select, active-low
//   rd_n       - read strobe, active-low
//   wr_n       - write strobe, always 1
//   dato_leido - last byte read
//   listo      - one-cycle done pulse
//   busy       - high in every state except IDLE (only with RTC_RD_BUSY_EN)
//
// Build option: define RTC_RD_BUSY_EN to add the busy output.

module rtc_read_ctrl #(
    parameter int unsigned T_ALE  = 4,
    parameter int unsigned T_HOLD = 2,
    parameter int unsigned T_RD   = 8,
    parameter int unsigned T_REC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arranque,
    input  logic [7:0] addr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ale,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] dato_leido,
    output logic       listo
`ifdef RTC_RD_BUSY_EN
    ,
    output logic       busy
`endif
);

    localparam int unsigned ALE_N  = (T_ALE  == 0) ? 1 : T_ALE;
    localparam int unsigned HOLD_N = (T_HOLD == 0) ? 1 : T_HOLD;
    localparam int unsigned RD_N_C = (T_RD   == 0) ? 1 : T_RD;
    localparam int unsigned REC_N  = (T_REC  == 0) ? 1 : T_REC;

    // The counter is loaded with (cycles - 1) on phase entry and the phase
    // ends in the cycle where it reads zero.
    localparam logic [7:0] ALE_LD  = 8'(ALE_N  - 1);
    localparam logic [7:0] HOLD_LD = 8'(HOLD_N - 1);
    localparam logic [7:0] RD_LD   = 8'(RD_N_C - 1);
    localparam logic [7:0] REC_LD  = 8'(REC_N  - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        HOLD,
        READ,
        RECOV,
        DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ad_out     <= '0;
            dato_leido <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && arranque) begin
                ad_out <= addr;
            end
            if (state == READ && cnt == '0) begin
                dato_leido <= ad_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ad_oe     = 1'b0;
        ale       = 1'b0;
        cs_n      = 1'b1;
        rd_n      = 1'b1;
        listo     = 1'b0;
        case (state)
            IDLE: begin
                if (arranque) begin
                    state_nxt = ADDR;
                    cnt_nxt   = ALE_LD;
                end
            end
            ADDR: begin
                ad_oe = 1'b1;
                ale   = 1'b1;
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            HOLD: begin
                ad_oe = 1'b1;
                if (cnt == '0) begin
                    state_nxt = READ;
                    cnt_nxt   = RD_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            READ: begin
                cs_n = 1'b0;
                rd_n = 1'b0;
                if (cnt == '0) begin
                    state_nxt = RECOV;
                    cnt_nxt   = REC_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            RECOV: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            DONE: begin
                listo     = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign wr_n = 1'b1;

`ifdef RTC_RD_BUSY_EN
    assign busy = (state != IDLE);
`endif

endmodule

// File: tb/tb_rtc_read_ctrl.sv
// tb_rtc_read_ctrl
//   Directed bench for rtc_read_ctrl: default timing instance plus a second
//   instance with all timing parameters at 0 (treated as 1).

module tb_rtc_read_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       arranque;
    logic       arranque_m;
    logic [7:0] addr;
    logic [7:0] ad_in;

    logic [7:0] ad_out, dato_leido;
    logic       ad_oe, ale, cs_n, rd_n, wr_n, listo;
    logic [7:0] ad_out_m, dato_leido_m;
    logic       ad_oe_m, ale_m, cs_n_m, rd_n_m, wr_n_m, listo_m;
`ifdef RTC_RD_BUSY_EN
    logic       busy, busy_m;
`endif

    always #5 clk = ~clk;

    rtc_read_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .arranque   (arranque),
        .addr       (addr),
        .ad_in      (ad_in),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .ale        (ale),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .dato_leido (dato_leido),
        .listo      (listo)
`ifdef RTC_RD_BUSY_EN
        ,
        .busy       (busy)
`endif
    );

    rtc_read_ctrl #(
        .T_ALE  (0),
        .T_HOLD (0),
        .T_RD   (0),
        .T_REC  (0)
    ) dut_min (
        .clk        (clk),
        .rst        (rst),
        .arranque   (arranque_m),
        .addr       (addr),
        .ad_in      (ad_in),
        .ad_out     (ad_out_m),
        .ad_oe      (ad_oe_m),
        .ale        (ale_m),
        .cs_n       (cs_n_m),
        .rd_n       (rd_n_m),
        .wr_n       (wr_n_m),
        .dato_leido (dato_leido_m),
        .listo      (listo_m)
`ifdef RTC_RD_BUSY_EN
        ,
        .busy       (busy_m)
`endif
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-transaction observations of the default instance
    int n_ale, first_ale, n_oe, n_oe_a, n_rd, n_listo, listo_at, listo_last;
    int n_clash, n_wr, n_busy;

    task automatic clr_stats();
        n_ale = 0; first_ale = -1; n_oe = 0; n_oe_a = 0; n_rd = 0;
        n_listo = 0; listo_at = -1; listo_last = -1;
        n_clash = 0; n_wr = 0; n_busy = 0;
    endtask

    task automatic sample(input int i, input logic [7:0] a);
        if (ad_oe && (!cs_n || !rd_n)) n_clash++;
        if (ale && !rd_n) n_clash++;
        if (!wr_n) n_wr++;
        if (ale) begin
            n_ale++;
            if (first_ale < 0) first_ale = i;
        end
        if (ad_oe) begin
            n_oe++;
            if (ad_out == a) n_oe_a++;
        end
        if (!rd_n) n_rd++;
        if (listo) begin
            n_listo++;
            if (listo_at < 0) listo_at = i;
            listo_last = i;
        end
`ifdef RTC_RD_BUSY_EN
        if (busy) n_busy++;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m_ale, m_rd, m_oe, m_at;

        rst = 1'b1; arranque = 1'b0; arranque_m = 1'b0;
        addr = '0; ad_in = '0;
        tick();
        tick();
        chk("rst_cs_n",  int'(cs_n), 1);
        chk("rst_rd_n",  int'(rd_n), 1);
        chk("rst_wr_n",  int'(wr_n), 1);
        chk("rst_ale",   int'(ale), 0);
        chk("rst_ad_oe", int'(ad_oe), 0);
        chk("rst_listo", int'(listo), 0);
        chk("rst_dato",  int'(dato_leido), 0);
        chk("rst_adout", int'(ad_out), 0);
`ifdef RTC_RD_BUSY_EN
        chk("rst_busy",  int'(busy), 0);
`endif
        rst = 1'b0;
        tick();

        // Basic read, default timing
        addr = 8'h21; ad_in = 8'h5A; arranque = 1'b1;
        clr_stats();
        for (int i = 0; i < 24; i++) begin
            tick();
            sample(i, 8'h21);
            if (listo) arranque = 1'b0;
        end
        chk("t1_first_ale", first_ale, 0);
        chk("t1_ale_cyc",   n_ale, 4);
        chk("t1_oe_cyc",    n_oe, 6);
        chk("t1_oe_addr",   n_oe_a, 6);
        chk("t1_rd_cyc",    n_rd, 8);
        chk("t1_listo_at",  listo_at, 18);
        chk("t1_listo_cnt", n_listo, 1);
        chk("t1_clash",     n_clash, 0);
        chk("t1_wr_low",    n_wr, 0);
        chk("t1_dato",      int'(dato_leido), 8'h5A);
`ifdef RTC_RD_BUSY_EN
        chk("t1_busy_cyc",  n_busy, 19);
        chk("t1_busy_idle", int'(busy), 0);
`endif

        // Data changes mid-READ and after capture; addr changes during HOLD
        ad_in = 8'h11; addr = 8'h21; arranque = 1'b1;
        clr_stats();
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 4)  addr = 8'h30;
            if (i == 10) ad_in = 8'h22;
            if (i == 13) chk("t2_dato_pre", int'(dato_leido), 8'h5A);
            if (i == 14) ad_in = 8'h33;
            if (i <= 18) chk("t2_adout", int'(ad_out), 8'h21);
            sample(i, 8'h21);
            if (listo) arranque = 1'b0;
        end
        chk("t2_oe_addr",  n_oe_a, 6);
        chk("t2_listo_at", listo_at, 18);
        chk("t2_dato",     int'(dato_leido), 8'h22);

        // Reset during the 3rd READ cycle, with arranque still high
        addr = 8'h44; ad_in = 8'h99; arranque = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 8) begin
                chk("t3_in_read", int'(rd_n), 0);
                rst = 1'b1;
            end
        end
        tick();
        chk("t3_cs_n",  int'(cs_n), 1);
        chk("t3_rd_n",  int'(rd_n), 1);
        chk("t3_ale",   int'(ale), 0);
        chk("t3_ad_oe", int'(ad_oe), 0);
        chk("t3_listo", int'(listo), 0);
        chk("t3_dato",  int'(dato_leido), 0);
        chk("t3_adout", int'(ad_out), 0);
        rst = 1'b0; arranque = 1'b0;
        clr_stats();
        for (int i = 0; i < 24; i++) begin
            tick();
            sample(i, 8'h44);
        end
        chk("t3_no_listo", n_listo, 0);
        chk("t3_no_ale",   n_ale, 0);

        // Back-to-back: arranque held through DONE
        addr = 8'h21; ad_in = 8'h5A; arranque = 1'b1;
        clr_stats();
        for (int i = 0; i < 45; i++) begin
            tick();
            sample(i, 8'h21);
            if (i == 19) begin
                chk("t4_gap_ale",   int'(ale), 0);
                chk("t4_gap_listo", int'(listo), 0);
            end
            if (i == 20) begin
                chk("t4_ale_again", int'(ale), 1);
                arranque = 1'b0;
            end
        end
        chk("t4_listo_cnt",  n_listo, 2);
        chk("t4_listo_1st",  listo_at, 18);
        chk("t4_listo_2nd",  listo_last, 38);
        chk("t4_ale_cyc",    n_ale, 8);
        chk("t4_clash",      n_clash, 0);
        chk("t4_dato",       int'(dato_leido), 8'h5A);

        // Zero timing parameters behave as one cycle each
        addr = 8'h7E; ad_in = 8'h3C; arranque_m = 1'b1;
        m_ale = 0; m_rd = 0; m_oe = 0; m_at = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ale_m) m_ale++;
            if (!rd_n_m) m_rd++;
            if (ad_oe_m) m_oe++;
            if (listo_m && m_at < 0) m_at = i;
            if (i == 0) chk("t5_adout", int'(ad_out_m), 8'h7E);
            if (listo_m) arranque_m = 1'b0;
        end
        chk("t5_ale_cyc",  m_ale, 1);
        chk("t5_oe_cyc",   m_oe, 2);
        chk("t5_rd_cyc",   m_rd, 1);
        chk("t5_listo_at", m_at, 4);
        chk("t5_dato",     int'(dato_leido_m), 8'h3C);
        // Idle default instance must hold its last byte despite ad_in changes
        chk("t5_main_hold", int'(dato_leido), 8'h5A);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
